// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - fixed-priority interrupt controller with claim/complete handshake
//
// Purpose:
//   Edge-latches NUM_SRC level interrupt lines into pending bits. It picks the
//   lowest-indexed pending & enabled source. That source is presented to the core
//   as one request plus ID. The service is tracked through ack (claim) and done
//   (complete). Software sees a 4-register bus window:
//     0x0 ENABLE  RW   per-source enable
//     0x4 PENDING RW1C pending bits, write 1 to clear
//     0x8 PRIO_ID RO   [7:0] lowest pending&enable index, [31] valid
//     0xC STATUS  RO   [1:0] state code, [15:8] latched ID
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   src_i        interrupt lines, level, synchronous to clk
//   data_i       bus write data
//   addr_i       bus address, only [3:0] decoded
//   we_i, req_i  bus write enable and access request
//   data_o       bus read data, combinational from addr_i, 0 during reset
//   ack_o        bus acknowledge, one cycle after any request
//   int_req_o    interrupt request to the core
//   int_id_o     ID of the current request, 0 outside REQ
//   int_ack_i    core claims the request
//   int_done_i   core finished the handler

module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic               req_i,
    output logic [31:0]        data_o,
    output logic               ack_o,
    output logic               int_req_o,
    output logic [7:0]         int_id_o,
    input  logic               int_ack_i,
    input  logic               int_done_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] OFF_ENABLE  = 4'h0;
    localparam logic [3:0] OFF_PENDING = 4'h4;
    localparam logic [3:0] OFF_PRIO_ID = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] clr_bus;
    logic [NUM_SRC-1:0] clr_claim;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] active_mask;

    state_t     state;
    state_t     state_next;
    logic [7:0] id;
    logic [7:0] id_next;
    logic [7:0] prio_idx;
    logic       prio_valid;
    logic       wr_en;
    logic       claim;

    // Only the low address nibble and NUM_SRC data bits carry meaning.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr_i[31:4], data_i};

    assign wr_en       = req_i & we_i;
    assign active_mask = pending & enable;
    assign claim       = (state == REQ) & int_ack_i;

    // A new rising edge only latches if the source is enabled in that same cycle.
    assign set_mask = src_i & ~src_q & enable;

    assign clr_bus = (wr_en && addr_i[3:0] == OFF_PENDING) ? data_i[NUM_SRC-1:0]
                                                           : '0;

    always_comb begin
        clr_claim = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_claim[i] = claim && (id == 8'(i));
        end
    end

    // Set is applied after clear, so a coincident edge keeps the bit at 1.
    assign pending_next = (pending & ~(clr_bus | clr_claim)) | set_mask;

    // Scan downwards so the lowest-indexed match is the last assignment.
    always_comb begin
        prio_idx   = '0;
        prio_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active_mask[i]) begin
                prio_idx   = 8'(i);
                prio_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable  <= '0;
            pending <= '0;
            src_q   <= '0;
            ack_o   <= 1'b0;
        end else begin
            src_q   <= src_i;
            pending <= pending_next;
            ack_o   <= req_i;
            if (wr_en && addr_i[3:0] == OFF_ENABLE) begin
                enable <= data_i[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            id    <= '0;
        end else begin
            state <= state_next;
            id    <= id_next;
        end
    end

    // The ID is latched only in IDLE, so it stays frozen through REQ and ACTIVE
    // regardless of later enable or pending changes.
    always_comb begin
        state_next = state;
        id_next    = id;
        int_req_o  = 1'b0;
        int_id_o   = '0;
        case (state)
            IDLE: begin
                if (prio_valid) begin
                    state_next = REQ;
                    id_next    = prio_idx;
                end
            end
            REQ: begin
                int_req_o = 1'b1;
                int_id_o  = id;
                if (int_ack_i) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (int_done_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        data_o = '0;
        if (!rst) begin
            case (addr_i[3:0])
                OFF_ENABLE:  data_o = 32'(enable);
                OFF_PENDING: data_o = 32'(pending);
                OFF_PRIO_ID: data_o = {prio_valid, 23'd0, prio_idx};
                OFF_STATUS:  data_o = {16'd0, id, 6'd0, state};
                default:     data_o = '0;
            endcase
        end
    end

endmodule
